theta_phase_gen: RTL and testbench

- Numerically-controlled phase source directly upstream of sincos_TOP.
- Keeps a fixed-point radian phase, steps it by a programmable increment, and wraps it into [-pi, pi).
- Converts each phase to an IEEE-754 double and drives the Theta_valid/Theta input of the sin/cos stage.
- Runs a programmable burst of samples at a programmable rate, so the M-sequence/sweep logic can request phase ramps without floating-point IP.

---
 rtl/theta_gen_pkg.sv | 37 +++
 rtl/fx2double.sv | 94 +++++++++
 rtl/theta_phase_gen.sv | 140 ++++++++++++++
 tb/tb_theta_phase_gen.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/theta_gen_pkg.sv
// Shared constants, FSM state type and the wrapped phase adder
// for the theta phase generator.
package theta_gen_pkg;

  localparam logic [32:0] PI_FX     = 33'h0_6487_ED51;
  localparam logic [32:0] TWO_PI_FX = 33'h0_C90F_DAA2;
  localparam int DOUBLE_BIAS = 1023;
  localparam int FRAC_BITS   = 29;
  localparam int DBL_EXP_W   = 11;
  localparam int DBL_FRAC_W  = 52;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH
  } state_e;

  // Steps are bounded below pi, so one correction lands back in [-pi, pi).
  function automatic logic [31:0] phase_wrap_add(
    input logic [31:0] ph,
    input logic [31:0] st
  );
    logic signed [33:0] s;
    logic signed [33:0] pi_s;
    logic signed [33:0] two_pi_s;
    pi_s     = $signed({1'b0, PI_FX});
    two_pi_s = $signed({1'b0, TWO_PI_FX});
    s = $signed({{2{ph[31]}}, ph}) + $signed({{2{st[31]}}, st});
    if (s >= pi_s) begin
      s = s - two_pi_s;
    end else if (s < -pi_s) begin
      s = s + two_pi_s;
    end
    return 32'(s);
  endfunction

endpackage

// File: rtl/fx2double.sv
// Two-stage exact signed fixed-point to IEEE-754 double converter
// with valid pass-through and a synchronous flush.
module fx2double
  import theta_gen_pkg::*;
#(
  parameter int IN_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            valid_i,
  input  logic [IN_W-1:0] fx_i,
  output logic            valid_o,
  output logic [63:0]     data_o,
  output logic [IN_W-1:0] fx_o,
  output logic            busy_o
);

  localparam int PW = $clog2(IN_W);

  logic            s2_vld_q, s2_vld_d;
  logic            s2_sign_q, s2_sign_d;
  logic [IN_W-1:0] s2_mag_q, s2_mag_d;
  logic [PW-1:0]   s2_p_q, s2_p_d;
  logic [IN_W-1:0] s2_fx_q, s2_fx_d;
  logic            out_vld_q, out_vld_d;
  logic [63:0]     out_data_q, out_data_d;
  logic [IN_W-1:0] out_fx_q, out_fx_d;

  logic [DBL_EXP_W-1:0]  exp_w;
  logic [DBL_FRAC_W-1:0] frac_w;

  always_comb begin
    s2_vld_d  = valid_i & ~flush_i;
    s2_sign_d = s2_sign_q;
    s2_mag_d  = s2_mag_q;
    s2_p_d    = s2_p_q;
    s2_fx_d   = s2_fx_q;
    if (valid_i) begin
      s2_sign_d = fx_i[IN_W-1];
      s2_mag_d  = fx_i[IN_W-1] ? (~fx_i + IN_W'(1)) : fx_i;
      s2_fx_d   = fx_i;
      s2_p_d    = '0;
      for (int i = 0; i < IN_W; i++) begin
        if (s2_mag_d[i]) s2_p_d = PW'(i);
      end
    end
  end

  // Leading one lands on bit 52 and is dropped as the hidden bit.
  always_comb begin
    exp_w  = DBL_EXP_W'(DOUBLE_BIAS - FRAC_BITS) + DBL_EXP_W'(s2_p_q);
    frac_w = DBL_FRAC_W'({s2_mag_q, {DBL_FRAC_W{1'b0}}} >> s2_p_q);
    out_vld_d  = s2_vld_q & ~flush_i;
    out_data_d = out_data_q;
    out_fx_d   = out_fx_q;
    if (s2_vld_q) begin
      out_fx_d = s2_fx_q;
      if (s2_mag_q == '0) begin
        out_data_d = '0;
      end else begin
        out_data_d = {s2_sign_q, exp_w, frac_w};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld_q   <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_mag_q   <= '0;
      s2_p_q     <= '0;
      s2_fx_q    <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_fx_q   <= '0;
    end else begin
      s2_vld_q   <= s2_vld_d;
      s2_sign_q  <= s2_sign_d;
      s2_mag_q   <= s2_mag_d;
      s2_p_q     <= s2_p_d;
      s2_fx_q    <= s2_fx_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_fx_q   <= out_fx_d;
    end
  end

  assign valid_o = out_vld_q;
  assign data_o  = out_data_q;
  assign fx_o    = out_fx_q;
  assign busy_o  = s2_vld_q;

endmodule

// File: rtl/theta_phase_gen.sv
// Burst phase generator: wrapped Q3.29 phase ramp converted to
// IEEE-754 doubles for the downstream sin/cos stage.
module theta_phase_gen
  import theta_gen_pkg::*;
#(
  parameter int DATA_WIDTH         = 64,
  parameter int CORDIC_PHASE_WIDTH = 32,
  parameter int CNT_WIDTH          = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic [CORDIC_PHASE_WIDTH-1:0] phase_init,
  input  logic [CORDIC_PHASE_WIDTH-1:0] phase_step,
  input  logic [CNT_WIDTH-1:0]          num_samples,
  input  logic [CNT_WIDTH-1:0]          interval,
  output logic                          busy,
  output logic                          done,
  output logic                          Theta_valid,
  output logic [DATA_WIDTH-1:0]         Theta,
  output logic [CORDIC_PHASE_WIDTH-1:0] phase_fx
);

  localparam int PW = CORDIC_PHASE_WIDTH;
  localparam int CW = CNT_WIDTH;

  state_e        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [PW-1:0] step_q, step_d;
  logic [CW-1:0] ivl_q, ivl_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] rem_q, rem_d;
  logic          s1_vld_q, s1_vld_d;
  logic [PW-1:0] s1_ph_q, s1_ph_d;
  logic          s1_last_q, s1_last_d;
  logic          s2_last_q, s2_last_d;
  logic          s3_last_q, s3_last_d;
  logic          zdone_q, zdone_d;
  logic          cv_busy;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    step_d    = step_q;
    ivl_d     = ivl_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    s1_vld_d  = 1'b0;
    s1_ph_d   = s1_ph_q;
    s1_last_d = 1'b0;
    s2_last_d = s1_vld_q & s1_last_q;
    s3_last_d = s2_last_q;
    zdone_d   = 1'b0;
    if (abort) begin
      state_d   = ST_IDLE;
      s2_last_d = 1'b0;
      s3_last_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            phase_d = phase_init;
            step_d  = phase_step;
            ivl_d   = (interval == '0) ? '0 : interval - CW'(1);
            cnt_d   = '0;
            rem_d   = num_samples;
            if (num_samples == '0) zdone_d = 1'b1;
            else                   state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (cnt_q == '0) begin
            s1_vld_d  = 1'b1;
            s1_ph_d   = phase_q;
            s1_last_d = (rem_q == CW'(1));
            phase_d   = phase_wrap_add(phase_q, step_q);
            rem_d     = rem_q - CW'(1);
            cnt_d     = ivl_q;
            if (rem_q == CW'(1)) state_d = ST_FLUSH;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        ST_FLUSH: begin
          if (!s1_vld_q && !cv_busy) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      step_q    <= '0;
      ivl_q     <= '0;
      cnt_q     <= '0;
      rem_q     <= '0;
      s1_vld_q  <= 1'b0;
      s1_ph_q   <= '0;
      s1_last_q <= 1'b0;
      s2_last_q <= 1'b0;
      s3_last_q <= 1'b0;
      zdone_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      step_q    <= step_d;
      ivl_q     <= ivl_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      s1_vld_q  <= s1_vld_d;
      s1_ph_q   <= s1_ph_d;
      s1_last_q <= s1_last_d;
      s2_last_q <= s2_last_d;
      s3_last_q <= s3_last_d;
      zdone_q   <= zdone_d;
    end
  end

  fx2double #(
    .IN_W(PW)
  ) u_fx2double (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush_i(abort),
    .valid_i(s1_vld_q),
    .fx_i   (s1_ph_q),
    .valid_o(Theta_valid),
    .data_o (Theta),
    .fx_o   (phase_fx),
    .busy_o (cv_busy)
  );

  assign done = zdone_q | (Theta_valid & s3_last_q);
  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_theta_phase_gen.sv
// Scoreboard bench for theta_phase_gen: expected samples are queued at
// launch and popped as Theta_valid appears.
module tb_theta_phase_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] phase_init = '0;
  logic [31:0] phase_step = '0;
  logic [15:0] num_samples = '0;
  logic [15:0] interval = '0;
  logic        busy, done, Theta_valid;
  logic [63:0] Theta;
  logic [31:0] phase_fx;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] th;
    logic [31:0] fx;
    logic        last;
    int          at;
  } exp_t;

  exp_t sb[$];

  theta_phase_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .phase_init (phase_init),
    .phase_step (phase_step),
    .num_samples(num_samples),
    .interval   (interval),
    .busy       (busy),
    .done       (done),
    .Theta_valid(Theta_valid),
    .Theta      (Theta),
    .phase_fx   (phase_fx)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] m_dbl(input logic [31:0] x);
    real r;
    r = real'($signed(x)) / 536870912.0;
    return $realtobits(r);
  endfunction

  function automatic logic [31:0] m_wrap(input logic [31:0] a,
                                         input logic [31:0] b);
    longint s;
    longint pi_l;
    longint two_pi_l;
    pi_l = 64'h6487ED51;
    two_pi_l = 64'hC90FDAA2;
    s = longint'($signed(a)) + longint'($signed(b));
    if (s >= pi_l) s = s - two_pi_l;
    else if (s < -pi_l) s = s + two_pi_l;
    return 32'(s);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_lit(input logic [63:0] th, input logic [31:0] fx,
                          input logic last, input int at);
    exp_t e;
    e.th = th; e.fx = fx; e.last = last; e.at = at;
    sb.push_back(e);
  endtask

  task automatic push_model(input logic [31:0] init, input logic [31:0] step,
                            input int num, input int ivl);
    logic [31:0] ph;
    int sp;
    ph = init;
    sp = (ivl == 0) ? 1 : ivl;
    for (int i = 0; i < num; i++) begin
      push_lit(m_dbl(ph), ph, (i == num - 1), 3 + i * sp);
      ph = m_wrap(ph, step);
    end
  endtask

  task automatic launch(input logic [31:0] init, input logic [31:0] step,
                        input int num, input int ivl);
    phase_init = init;
    phase_step = step;
    num_samples = 16'(num);
    interval = 16'(ivl);
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic drain(input string name, input int budget, input int poke_at);
    exp_t e;
    for (int k = 1; k <= budget; k++) begin
      start = (k == poke_at);
      if (k == poke_at) begin
        phase_init = 32'h1555_5555;
        num_samples = 16'd7;
      end
      cyc();
      start = 1'b0;
      if (Theta_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL %s extra_valid at cycle %0d", name, k);
        end else begin
          e = sb.pop_front();
          checks += 3;
          if (Theta !== e.th) begin
            errors++;
            $display("FAIL %s theta got %h exp %h", name, Theta, e.th);
          end
          if (phase_fx !== e.fx) begin
            errors++;
            $display("FAIL %s phase_fx got %h exp %h", name, phase_fx, e.fx);
          end
          if (done !== e.last) begin
            errors++;
            $display("FAIL %s done got %b exp %b", name, done, e.last);
          end
          if (k != e.at) begin
            errors++;
            $display("FAIL %s timing got %0d exp %0d", name, k, e.at);
          end
          if (sb.size() == 0) begin
            checks++;
            if (busy !== 1'b1) begin
              errors++;
              $display("FAIL %s busy_at_done got %b exp 1", name, busy);
            end
            cyc();
            checks += 2;
            if (busy !== 1'b0) begin
              errors++;
              $display("FAIL %s busy_after got %b exp 0", name, busy);
            end
            if (done !== 1'b0) begin
              errors++;
              $display("FAIL %s done_after got %b exp 0", name, done);
            end
            for (int t = 0; t < 4; t++) begin
              cyc();
              checks++;
              if (Theta_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s tail_valid got 1 exp 0", name);
              end
            end
            return;
          end
        end
      end else begin
        checks++;
        if (done !== 1'b0) begin
          errors++;
          $display("FAIL %s stray_done at cycle %0d", name, k);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s timeout pending %0d exp 0", name, sb.size());
    end
    sb.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) cyc();
    checks++;
    if ({busy, done, Theta_valid, Theta, phase_fx} !== '0) begin
      errors++;
      $display("FAIL reset outputs got %b%b%b %h %h exp all 0",
               busy, done, Theta_valid, Theta, phase_fx);
    end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_basic();
    push_lit(64'h3FF0_0000_0000_0000, 32'h2000_0000, 1'b0, 3);
    push_lit(64'h3FF8_0000_0000_0000, 32'h3000_0000, 1'b0, 4);
    push_lit(64'h4000_0000_0000_0000, 32'h4000_0000, 1'b1, 5);
    launch(32'h2000_0000, 32'h1000_0000, 3, 1);
    drain("basic", 20, 0);
  endtask

  task automatic test_interval_wrap();
    push_lit(64'h4008_0000_0000_0000, 32'h6000_0000, 1'b0, 3);
    push_lit(m_dbl(32'h9EF0_255E), 32'h9EF0_255E, 1'b1, 7);
    launch(32'h6000_0000, 32'h0800_0000, 2, 4);
    drain("wrap_pos", 20, 0);
  endtask

  task automatic test_negative();
    push_lit(64'h3FF0_0000_0000_0000, 32'h2000_0000, 1'b0, 3);
    push_lit(64'hBFF0_0000_0000_0000, 32'hE000_0000, 1'b1, 4);
    launch(32'h2000_0000, 32'hC000_0000, 2, 0);
    drain("negative", 20, 0);
    push_lit(64'h0, 32'h0, 1'b1, 3);
    launch(32'h0, 32'h0100_0000, 1, 1);
    drain("zero_phase", 20, 0);
  endtask

  task automatic test_zero_count();
    launch(32'h2000_0000, 32'h1000_0000, 0, 1);
    checks += 3;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL zero_count done got %b exp 1", done);
    end
    if (Theta_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_count valid got %b exp 0", Theta_valid);
    end
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_count busy got %b exp 0", busy);
    end
    for (int t = 0; t < 6; t++) begin
      cyc();
      checks++;
      if (done !== 1'b0 || Theta_valid !== 1'b0) begin
        errors++;
        $display("FAIL zero_count quiet got %b%b exp 00", done, Theta_valid);
      end
    end
  endtask

  task automatic test_start_busy();
    push_model(32'hE800_0000, 32'h0400_0000, 3, 3);
    launch(32'hE800_0000, 32'h0400_0000, 3, 3);
    drain("start_busy", 30, 2);
  endtask

  task automatic test_abort();
    int seen;
    launch(32'h0, 32'h0100_0000, 5, 2);
    cyc();
    cyc();
    abort = 1'b1;
    start = 1'b1;
    cyc();
    abort = 1'b0;
    start = 1'b0;
    checks += 3;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort busy got %b exp 0", busy);
    end
    if (Theta_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort valid got %b exp 0", Theta_valid);
    end
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL abort done got %b exp 0", done);
    end
    seen = 0;
    for (int t = 0; t < 12; t++) begin
      cyc();
      if (Theta_valid || done || busy) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort quiet got %0d active cycles exp 0", seen);
    end
    test_basic();
  endtask

  task automatic test_random();
    logic [31:0] init, step;
    int num, ivl;
    for (int b = 0; b < 6; b++) begin
      init = 32'($urandom_range(0, 32'hC90F_DAA1)) - 32'h6487_ED51;
      step = 32'($urandom_range(0, 32'hC90F_DAA0)) - 32'h6487_ED50;
      num = $urandom_range(1, 6);
      ivl = $urandom_range(0, 3);
      push_model(init, step, num, ivl);
      launch(init, step, num, ivl);
      drain("random", 40, 0);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    launch(32'h2000_0000, 32'h0010_0000, 10, 1);
    repeat (5) cyc();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, Theta_valid, Theta, phase_fx} !== '0) begin
      errors++;
      $display("FAIL reset_mid outputs got %b%b%b %h %h exp all 0",
               busy, done, Theta_valid, Theta, phase_fx);
    end
    cyc();
    rst_n = 1'b1;
    seen = 0;
    for (int t = 0; t < 10; t++) begin
      cyc();
      if (Theta_valid || busy || done) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_mid quiet got %0d active cycles exp 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_interval_wrap();
    test_negative();
    test_zero_count();
    test_start_busy();
    test_abort();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
